// File: rtl/mwb_sequencer_if.sv
// rtl/mwb_sequencer_if.sv - bus bundle between microinstruction source, branch unit and the address sequencer
//
// Purpose: groups the sequencer's decode inputs, its branch-unit drive and
// return path, and its address/status outputs into one bundle.
// Signals:
//   op     [2:0]    sequencer opcode from the microinstruction register
//   d      [AW-1:0] branch/base address field
//   mask   [3:0]    test select mask for multiway/wait ops
//   bu_i   [3:0]    to branch unit instruction inputs
//   bu_oe_          to branch unit output enables (active low)
//   orx    [3:0]    from branch unit OR outputs (tri-stated when disabled)
//   y      [AW-1:0] registered microprogram address
//   stall           high while WAIT holds the address
//   ovf/unf/tmo     sticky stack overflow / underflow / wait timeout
// Modports: slave = the sequencer, master = the surrounding datapath.

interface mwb_sequencer_if #(
  parameter int AW = 12
);
  logic [2:0]    op;
  logic [AW-1:0] d;
  logic [3:0]    mask;
  logic [3:0]    bu_i;
  logic          bu_oe_;
  logic [3:0]    orx;
  logic [AW-1:0] y;
  logic          stall;
  logic          ovf;
  logic          unf;
  logic          tmo;

  modport slave (
    input  op, d, mask, orx,
    output bu_i, bu_oe_, y, stall, ovf, unf, tmo
  );

  modport master (
    output op, d, mask, orx,
    input  bu_i, bu_oe_, y, stall, ovf, unf, tmo
  );
endinterface

// File: rtl/mwb_sequencer.sv
// rtl/mwb_sequencer.sv - microprogram address sequencer with 16-way branch unit support
//
// Purpose: computes the next control-store address each cycle from the
// current address, opcode, branch field and the branch unit's OR outputs.
// Supports increment, jump, multiway branch, call, multiway call, return and
// wait-on-test, with a small subroutine stack and sticky error flags.
// Ports:
//   cp   clock, rising edge active
//   rst  asynchronous active-high reset
//   bus  mwb_sequencer_if.slave (op, d, mask, orx in; bu_i, bu_oe_, y,
//        stall, ovf, unf, tmo out)
// Optional feature: define MWB_WAIT_TIMEOUT_EN to bound WAIT stalls to TMO
// cycles; on expiry the sequencer jumps to d and sets the sticky tmo flag.
// Without it tmo is tied 0 and WAIT may stall indefinitely.

module mwb_sequencer #(
  parameter int AW  = 12,
  parameter int SD  = 4,
  parameter int TMO = 255
) (
  input  logic            cp,
  input  logic            rst,
  mwb_sequencer_if.slave  bus
);

  if (AW < 5 || SD < 2 || SD > 16 || TMO < 1) begin : g_param_check
    $error("mwb_sequencer: parameter out of range");
  end

  // sp counts 0..SD inclusive, so it needs one more code than the index.
  localparam int SPW = $clog2(SD + 1);
  localparam int IW  = $clog2(SD);
  localparam logic [SPW-1:0] SD_C = SPW'(SD);

  typedef enum logic [2:0] {
    OP_CLR    = 3'b000,
    OP_CONT   = 3'b001,
    OP_JMP    = 3'b010,
    OP_MWB    = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_MWCALL = 3'b110,
    OP_WAIT   = 3'b111
  } op_e;

  op_e            op;
  logic [AW-1:0]  y_q, y_nxt, y_inc, mw, call_tgt;
  logic [SPW-1:0] sp_q, sp_nxt, sp_dec;
  logic [AW-1:0]  stack [SD];
  logic           ovf_q, unf_q;
  logic           push, set_ovf, set_unf;
  logic           mw_sel;
  logic [3:0]     orx_eff;
  logic           wait_stall, tmo_fire;

  assign op = op_e'(bus.op);

  // The branch unit is only enabled for ops that test conditions; orx is
  // masked otherwise so floating/unknown bus values never leak into y.
  assign mw_sel      = (op == OP_MWB) || (op == OP_MWCALL) || (op == OP_WAIT);
  assign bus.bu_i    = mw_sel ? bus.mask : 4'b0000;
  assign bus.bu_oe_  = ~mw_sel;
  assign orx_eff     = mw_sel ? bus.orx : 4'b0000;

  assign mw       = {bus.d[AW-1:4], bus.d[3:0] | orx_eff};
  assign y_inc    = y_q + AW'(1);
  assign sp_dec   = sp_q - SPW'(1);
  assign call_tgt = (op == OP_MWCALL) ? mw : bus.d;

  assign wait_stall = (op == OP_WAIT) && (orx_eff == 4'b0000);
  // A timeout releases the stall in the same cycle it redirects to d.
  assign bus.stall  = wait_stall && !tmo_fire;

`ifdef MWB_WAIT_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  logic [CW-1:0] wcnt_q;
  logic          tmo_q;

  assign tmo_fire = wait_stall && (wcnt_q == TMO_C);
  assign bus.tmo  = tmo_q;

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (tmo_fire) begin
        wcnt_q <= '0;
        tmo_q  <= 1'b1;
      end else if (wait_stall) begin
        wcnt_q <= wcnt_q + CW'(1);
      end else begin
        wcnt_q <= '0;
      end
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign bus.tmo  = 1'b0;
`endif

  always_comb begin
    y_nxt   = y_q;
    sp_nxt  = sp_q;
    push    = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case (op)
      OP_CLR: begin
        y_nxt  = '0;
        sp_nxt = '0;
      end
      OP_CONT: y_nxt = y_inc;
      OP_JMP:  y_nxt = bus.d;
      OP_MWB:  y_nxt = mw;
      OP_CALL, OP_MWCALL: begin
        // A full stack drops the push but the call still transfers control.
        y_nxt = call_tgt;
        if (sp_q < SD_C) begin
          push   = 1'b1;
          sp_nxt = sp_q + SPW'(1);
        end else begin
          set_ovf = 1'b1;
        end
      end
      OP_RET: begin
        if (sp_q != '0) begin
          y_nxt  = stack[sp_dec[IW-1:0]];
          sp_nxt = sp_dec;
        end else begin
          set_unf = 1'b1;
          y_nxt   = y_inc;
        end
      end
      OP_WAIT: begin
        if (tmo_fire)        y_nxt = bus.d;
        else if (wait_stall) y_nxt = y_q;
        else                 y_nxt = y_inc;
      end
      default: y_nxt = y_q;
    endcase
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      y_q  <= y_nxt;
      sp_q <= sp_nxt;
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end

  // Stack contents need no reset; gating the write with !rst keeps an
  // aborted call from leaving a partial entry behind.
  always_ff @(posedge cp) begin
    if (push && !rst) stack[sp_q[IW-1:0]] <= y_inc;
  end

  assign bus.y   = y_q;
  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;

endmodule

// File: doc/mwb_sequencer.md
Name: mwb_sequencer

Overview:
- Microprogram address sequencer that drives an external 16-way branch control unit (am29803-style) and consumes its OR outputs.
- Each cycle it decodes a 3-bit sequencer opcode and performs one of: increment, jump, multiway branch, call, multiway call, return, or wait-on-test.
- During multiway ops it drives the branch unit's mask and enables, then ORs the returned bits into the low nibble of the branch field.
- Owns a small subroutine stack and sticky error flags; sits between the microinstruction register and the control-store address bus.

Parameters:
AW, 12, microprogram address width (>=5)
SD, 4, subroutine stack depth (2..16)
TMO, 255, wait timeout in cycles (used only with optional feature)

Ports:
cp  input  1  clock, rising edge active
rst  input  1  asynchronous active-high reset
op  input  3  sequencer opcode from microinstruction
d  input  AW  branch/base address field
mask  input  4  test select mask for multiway/wait ops
bu_i  output  4  to branch unit instruction inputs
bu_oe_  output  1  to branch unit oe1_/oe2_ (active low)
orx  input  4  from branch unit OR outputs (tri-stated when disabled)
y  output  AW  registered microprogram address
stall  output  1  high while WAIT holds the address
ovf  output  1  sticky stack overflow
unf  output  1  sticky stack underflow
tmo  output  1  sticky wait timeout (optional feature only; else tied 0)

Behaviour:
- Reset: one clock, cp. rst is asynchronous and active-high. While asserted: y=0, sp=0, stack contents don't-care, ovf=unf=tmo=0, wait counter=0.
- y, sp, stack and flags update only on the rising edge of cp. Next address is computed combinationally from the current y, op, d and orx, so latency is one cycle.
- Branch unit drive (combinational):
  - op in {MWB, MWCALL, WAIT}: bu_i=mask, bu_oe_=0.
  - Otherwise: bu_i=0, bu_oe_=1.
- orx is used only when bu_oe_=0. Any x/z on orx in other cycles is ignored.
- Multiway target: mw = {d[AW-1:4], d[3:0] | orx}.
- Opcodes:
  - 000 CLR: y<=0; sp<=0. Flags unchanged.
  - 001 CONT: y<=y+1, wraps from all-ones to 0.
  - 010 JMP: y<=d.
  - 011 MWB: y<=mw.
  - 100 CALL:
    - sp<SD: stack[sp]<=y+1; sp<=sp+1; y<=d.
    - sp==SD: push dropped, ovf<=1, y<=d anyway.
  - 101 RET:
    - sp>0: y<=stack[sp-1]; sp<=sp-1.
    - sp==0: unf<=1, y<=y+1.
  - 110 MWCALL: same as CALL, but the target is mw.
  - 111 WAIT:
    - orx==0: y held, stall=1.
    - orx!=0: y<=y+1, stall=0.
    - stall is combinational: (op==111 && orx==0). A mask of 0 waits forever.
- Wrap rule: y+1 wraps modulo 2^AW. The return address pushed from y=all-ones is 0.
- rst asserted during WAIT or CALL aborts immediately. No partial push survives.
- ovf/unf/tmo clear only on rst.

Optional Feature:
- Macro: MWB_WAIT_TIMEOUT_EN.
- Defined:
  - A wait counter increments each stalled WAIT cycle and clears on any non-stalled cycle.
  - When the counter reaches TMO while still stalled: y<=d, tmo<=1, counter<=0, stall=0 on that cycle.
- Not defined: no counter, WAIT may stall indefinitely, tmo tied 0.

Test Plan:
- Reset then CONT x3 -> y = 0,1,2,3. Assert rst asynchronously mid-cycle -> y=0 before the next edge.
- y=0x010, MWB, d=0x120, mask=4'b1010, t=4'b1111 (branch unit gives orx=4'b0011) -> y=0x123; bu_i=4'b1010, bu_oe_=0 during the op, bu_oe_=1 after.
- y=0x050, CALL d=0x200; then RET -> y=0x200, then 0x051, sp back to 0, ovf=unf=0.
- Five nested CALLs with SD=4 -> fifth jumps but ovf=1. Then RET x4 returns in LIFO order; a fifth RET sets unf=1 and increments y.
- y=0x030, WAIT, mask=4'b0001, t[0]=0 for 3 cycles then 1 -> y=0x030 held, stall=1 for 3 cycles, then y=0x031.
- MWB_WAIT_TIMEOUT_EN, TMO=4, WAIT with d=0x3F0, t never set -> y=0x3F0 after timeout, tmo=1; without the macro, y is still held after 20 cycles.
